vector_interp_seq: RTL
======================

# vector_interp_seq

Sequencer that streams 128-bit pixel words (four 32-bit lanes, lane 0 = bits 31:0) through the combinational vector ALU in its interpolation modes. Each accepted word is expanded into three output words: ALUop 101, then 110, then 111. The 111 step needs lane 0 of the following word, so the block holds a one-word lookahead buffer. It sits between the pixel fetch stream and the result write-back stream. It owns the ALU's ALUop/VCSub/inputA/inputB and captures the ALU's out into a registered output stage with valid/ready flow control.

## Interface
- No parameters. Lane width is fixed at 32 and the word width at 128, matching the vector ALU.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input word offered.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  128  four pixels.
- in_last  in  1  word is the last of its row.
- alu_sub  out  1  drives VCSub; constant 0.
- alu_op  out  3  drives ALUop.
- alu_a  out  128  drives inputA.
- alu_b  out  128  drives inputB.
- alu_out  in  128  ALU result (combinational, same cycle).
- out_valid  out  1  result word valid (registered).
- out_ready  in  1  downstream accepts.
- out_data  out  128  result word (registered).
- out_last  out  1  final result word of a row (registered).
- busy  out  1  state != IDLE or out_valid.

## Operation
- Registers:
  - cur[127:0] and cur_last: word being expanded.
  - nxt[127:0], nxt_last and nxt_valid: lookahead buffer.
  - state: IDLE, EXP0, EXP1, EXP2.
- Input acceptance (accept = in_valid && in_ready):
  - in_ready is 1 in IDLE.
  - In EXP0/EXP1/EXP2, in_ready = !cur_last && !nxt_valid.
  - in_ready is 0 while reset is high.
  - In IDLE, an accept loads cur and cur_last, then goes to EXP0.
  - In any other state, an accept loads nxt and nxt_last and sets nxt_valid.
- ALU drive:
  - EXP0: alu_op=101. EXP1: alu_op=110. EXP2: alu_op=111. IDLE: alu_op=000.
  - alu_a = cur in all states.
  - alu_b = 0, except in EXP2, where lane 0 = (cur_last ? cur[127:96] : nxt[31:0]) and lanes 1–3 are 0.
  - The EXP2 lane-0 rule replicates the row-edge pixel at the end of a row.
  - Lanes 1–3 of alu_b must be 0 so that unit op 000 passes the inputA lanes unchanged.
- Issue condition:
  - slot = !out_valid || out_ready.
  - go = slot && (state==EXP0 || state==EXP1 || (state==EXP2 && (nxt_valid || cur_last))).
- On go:
  - out_data <= alu_out, out_valid <= 1, and out_last <= (state==EXP2 && cur_last).
  - EXP0 -> EXP1, EXP1 -> EXP2.
  - EXP2 with cur_last -> IDLE.
  - EXP2 without cur_last: cur <= nxt, cur_last <= nxt_last, nxt_valid <= 0, then -> EXP0.
- If slot holds but go does not, out_valid <= 0.
- If !go in a non-IDLE state, the state holds and the ALU inputs stay stable (stall).
- Simultaneous events in EXP2 without cur_last: go (consuming nxt) and an input accept cannot happen together, because in_ready requires !nxt_valid and go requires nxt_valid.
- Each input word produces exactly 3 output words, in order. A row of N words produces 3N words, with out_last on word 3N only.

## Timing
- Reset values:
  - state=IDLE; cur, nxt, cur_last, nxt_last, nxt_valid all 0.
  - out_valid=0, out_data=0, out_last=0.
  - busy=0, alu_op=000, alu_sub=0.
- Latency:
  - Word accepted in IDLE at cycle T: EXP0 is in T+1, and out_valid=1 with the 101 result at T+2.
- Throughput with out_ready held 1 and input always available: one output word per cycle, 3 cycles per input word, no bubbles between words of a row.
- A missing lookahead word stalls in EXP2 with no output. out_valid drops after the pending word drains.
- Output stage rule: out_data and out_last change only when !out_valid || out_ready.
- Reset asserted mid-row discards cur, nxt and the pending output immediately, with no further output beats.

## Test plan
- Single-word row: cur lanes (l0..l3) = 10,20,30,40, in_last=1, out_ready=1.
  - Required outputs: 10,13,16,20 / 23,26,30,33 / 36,40,40,40.
  - out_last set only on the third word; out_valid first at T+2; then IDLE.
- Two-word row: word A = 10,20,30,40; word B = 50,60,70,80 with last=1.
  - Third output of A: 36,40,43,46.
  - 6 outputs on consecutive cycles; in_ready for B asserted during A's EXP0.
- Late lookahead: B presented 5 cycles after A.
  - EXP2 holds alu_op=111 with no output beats; the third output of A appears the cycle after B's accept plus one.
- Backpressure: out_ready held 0 for 4 cycles mid-row.
  - out_data stable, state frozen, no loss or duplication.
  - Output sequence identical to the no-backpressure case.
- Reset mid-row: assert reset during A's EXP1.
  - Same cycle: out_valid=0 and state IDLE.
  - After release, a new single-word row expands correctly.
- Random stream: random valid/ready and row lengths 1–8, checked against a software model.
  - 3N outputs per row; out_last count equals row count.

Source files
------------

// File: rtl/vector_interp_seq.sv
// -----------------------------------------------------------------------------
// vector_interp_seq
//
// Streams 128-bit pixel words (four 32-bit lanes, lane 0 = bits 31:0) through
// an external combinational vector ALU in its interpolation modes. Every
// accepted word is expanded into three result words, issued with ALUop 101,
// 110 and 111 in that order. The 111 step needs lane 0 of the following word,
// so a one-word lookahead buffer sits next to the word being expanded. At the
// end of a row the edge pixel (lane 3) stands in for the missing neighbour.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   in_valid   input word offered
//   in_ready   input word accepted this cycle (when in_valid)
//   in_data    four input pixels
//   in_last    input word is the last of its row
//   alu_sub    VCSub drive, tied low
//   alu_op     ALUop drive (000 when idle)
//   alu_a      inputA drive (the word being expanded)
//   alu_b      inputB drive (only lane 0 is ever non-zero)
//   alu_out    ALU result, combinational in the same cycle
//   out_valid  result word valid (registered)
//   out_ready  downstream accepts the result word
//   out_data   result word (registered)
//   out_last   final result word of a row (registered)
//   busy       expansion in progress or a result still pending
// -----------------------------------------------------------------------------
module vector_interp_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         alu_sub,
  output logic [2:0]   alu_op,
  output logic [127:0] alu_a,
  output logic [127:0] alu_b,
  input  logic [127:0] alu_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP0 = 2'd1,
    EXP1 = 2'd2,
    EXP2 = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nx;

  logic [127:0] cur;
  logic         cur_last;
  logic [127:0] nxt;
  logic         nxt_last;
  logic         nxt_valid;

  logic         accept;
  logic         slot;
  logic         go;

  // ---------------------------------------------------------------------------
  // Next state, handshake and ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nx = state;
    alu_op   = 3'b000;
    alu_b    = '0;
    go       = 1'b0;

    // Once the row's last word is held, nothing more is taken until the row
    // has fully drained back to IDLE; otherwise one lookahead slot is free.
    in_ready = !reset && ((state == IDLE) || (!cur_last && !nxt_valid));
    accept   = in_valid && in_ready;
    slot     = !out_valid || out_ready;

    unique case (state)
      IDLE: begin
        if (accept) state_nx = EXP0;
      end
      EXP0: begin
        alu_op = 3'b101;
        go     = slot;
        if (go) state_nx = EXP1;
      end
      EXP1: begin
        alu_op = 3'b110;
        go     = slot;
        if (go) state_nx = EXP2;
      end
      EXP2: begin
        alu_op = 3'b111;
        // Right-hand neighbour of lane 3: the next word's first pixel, or the
        // edge pixel replicated at the end of a row. Lanes 1-3 stay zero.
        alu_b[31:0] = cur_last ? cur[127:96] : nxt[31:0];
        go          = slot && (nxt_valid || cur_last);
        if (go) state_nx = cur_last ? IDLE : EXP0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign alu_a   = cur;
  assign alu_sub = 1'b0;
  assign busy    = (state != IDLE) || out_valid;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Word buffers and registered output stage
  // ---------------------------------------------------------------------------
  // An accept into nxt and a go that consumes nxt never coincide: accepting
  // needs nxt_valid low, consuming needs it high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= '0;
      cur_last  <= 1'b0;
      nxt       <= '0;
      nxt_last  <= 1'b0;
      nxt_valid <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
          cur      <= in_data;
          cur_last <= in_last;
        end else begin
          nxt       <= in_data;
          nxt_last  <= in_last;
          nxt_valid <= 1'b1;
        end
      end

      if (go) begin
        out_data  <= alu_out;
        out_valid <= 1'b1;
        out_last  <= (state == EXP2) && cur_last;
        if ((state == EXP2) && !cur_last) begin
          cur       <= nxt;
          cur_last  <= nxt_last;
          nxt_valid <= 1'b0;
        end
      end else if (slot) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
